// File: rtl/resized_crop.sv
// Crop-and-resize reader: walks a SxS window of a 28x28 BRAM image and emits 28x28 pixels.
// Define RESIZED_CROP_RANDOM_EN to draw window size/offset from an LFSR instead of fixed 20 at (4,4).
module resized_crop #(
  parameter int IMG_DIM = 28,
  parameter int ADDR_W  = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              image_done,
  output logic [7:0]        pixel_o,
  output logic              pixel_valid,
  output logic [ADDR_W-1:0] bram_address,
  input  logic [7:0]        bram_data
);
  localparam int CW = $clog2(IMG_DIM);
  localparam int AW = CW + 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       c_q, c_d, r_q, r_d, scol_q, scol_d, x0_q, x0_d;
  logic [AW-1:0]       col_acc_q, col_acc_d, row_acc_q, row_acc_d, s_q, s_d;
  logic [ADDR_W-1:0]   row_base_q, row_base_d, addr_q, addr_d;
  logic                data_valid_q, data_valid_d, data_last_q, data_last_d;
  logic                pixel_valid_q, pixel_valid_d;
  logic [7:0]          pixel_o_q, pixel_o_d;

  logic [AW-1:0]       s_new;
  logic [CW-1:0]       x0_new, y0_new;
  logic [ADDR_W-1:0]   base_new;
  logic [AW-1:0]       col_sum, row_sum;
  logic                last_px;

`ifdef RESIZED_CROP_RANDOM_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic [AW-1:0] lim;
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    s_new  = AW'(20) + AW'(lfsr_q[2:0]);
    lim    = AW'(IMG_DIM) - s_new;
    x0_new = (AW'(lfsr_q[5:3]) < lim) ? CW'(lfsr_q[5:3]) : CW'(lim);
    y0_new = (AW'(lfsr_q[8:6]) < lim) ? CW'(lfsr_q[8:6]) : CW'(lim);
  end
`else
  assign s_new  = AW'(20);
  assign x0_new = CW'(4);
  assign y0_new = CW'(4);
`endif

  // Starting row base y0*IMG_DIM built by shift-add, one term per set bit of y0.
  always_comb begin
    base_new = '0;
    for (int i = 0; i < CW; i++) begin
      if (y0_new[i]) base_new = base_new + (ADDR_W'(IMG_DIM) << i);
    end
  end

  assign col_sum = col_acc_q + s_q;
  assign row_sum = row_acc_q + s_q;
  assign last_px = (state_q == READ) && (c_q == CW'(IMG_DIM - 1)) && (r_q == CW'(IMG_DIM - 1));

  always_comb begin
    state_d       = state_q;
    c_d           = c_q;
    r_d           = r_q;
    scol_d        = scol_q;
    x0_d          = x0_q;
    s_d           = s_q;
    col_acc_d     = col_acc_q;
    row_acc_d     = row_acc_q;
    row_base_d    = row_base_q;
    addr_d        = addr_q;
    data_valid_d  = (state_q == READ);
    data_last_d   = last_px;
    pixel_valid_d = data_valid_q;
    pixel_o_d     = data_valid_q ? bram_data : pixel_o_q;
    case (state_q)
      IDLE: begin
        addr_d = '0;
        if (start) begin
          state_d    = READ;
          c_d        = '0;
          r_d        = '0;
          col_acc_d  = '0;
          row_acc_d  = '0;
          s_d        = s_new;
          x0_d       = x0_new;
          scol_d     = x0_new;
          row_base_d = base_new;
          addr_d     = base_new + ADDR_W'(x0_new);
        end
      end
      READ: begin
        if (c_q == CW'(IMG_DIM - 1)) begin
          if (r_q == CW'(IMG_DIM - 1)) begin
            state_d = DRAIN;
            addr_d  = '0;
          end else begin
            // Row advance: column walk restarts at the left edge of the window.
            r_d       = r_q + CW'(1);
            c_d       = '0;
            col_acc_d = '0;
            scol_d    = x0_q;
            if (row_sum >= AW'(IMG_DIM)) begin
              row_acc_d  = row_sum - AW'(IMG_DIM);
              row_base_d = row_base_q + ADDR_W'(IMG_DIM);
            end else begin
              row_acc_d  = row_sum;
            end
            addr_d = row_base_d + ADDR_W'(x0_q);
          end
        end else begin
          c_d = c_q + CW'(1);
          if (col_sum >= AW'(IMG_DIM)) begin
            col_acc_d = col_sum - AW'(IMG_DIM);
            scol_d    = scol_q + CW'(1);
          end else begin
            col_acc_d = col_sum;
          end
          addr_d = row_base_q + ADDR_W'(scol_d);
        end
      end
      DRAIN: begin
        if (!data_valid_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      c_q           <= '0;
      r_q           <= '0;
      scol_q        <= '0;
      x0_q          <= '0;
      s_q           <= '0;
      col_acc_q     <= '0;
      row_acc_q     <= '0;
      row_base_q    <= '0;
      addr_q        <= '0;
      data_valid_q  <= 1'b0;
      data_last_q   <= 1'b0;
      pixel_valid_q <= 1'b0;
      pixel_o_q     <= '0;
`ifdef RESIZED_CROP_RANDOM_EN
      lfsr_q        <= 16'hACE1;
`endif
    end else begin
      state_q       <= state_d;
      c_q           <= c_d;
      r_q           <= r_d;
      scol_q        <= scol_d;
      x0_q          <= x0_d;
      s_q           <= s_d;
      col_acc_q     <= col_acc_d;
      row_acc_q     <= row_acc_d;
      row_base_q    <= row_base_d;
      addr_q        <= addr_d;
      data_valid_q  <= data_valid_d;
      data_last_q   <= data_last_d;
      pixel_valid_q <= pixel_valid_d;
      pixel_o_q     <= pixel_o_d;
`ifdef RESIZED_CROP_RANDOM_EN
      lfsr_q        <= lfsr_d;
`endif
    end
  end

  assign bram_address = addr_q;
  assign pixel_o      = pixel_o_q;
  assign pixel_valid  = pixel_valid_q;
  assign image_done   = data_last_q;
endmodule

// File: tb/tb_resized_crop.sv
// Directed bench for resized_crop (default build: S=20, X0=Y0=4) with a BRAM model
// and a nearest-neighbour reference built from floor((i*S)/28).
module tb_resized_crop;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        image_done, pixel_valid;
  logic [7:0]  pixel_o, bram_data;
  logic [10:0] bram_address;

  resized_crop #(.IMG_DIM(28), .ADDR_W(11)) dut (
    .clk(clk), .reset(reset), .start(start), .image_done(image_done),
    .pixel_o(pixel_o), .pixel_valid(pixel_valid),
    .bram_address(bram_address), .bram_data(bram_data)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:2047];
  initial for (int a = 0; a < 2048; a++) mem[a] = 8'(a % 256);

  always @(posedge clk or negedge reset) begin
    if (!reset) bram_data <= 8'd0;
    else        bram_data <= mem[bram_address];
  end

  int tests = 0, fails = 0;
  int pix_cnt = 0, done_cnt = 0;
  int h1 = 0, h2 = 0;
  int got [0:783];

  // Output pixel n samples window row floor(r*S/28), column floor(c*S/28).
  function automatic int exp_addr(int n);
    int r = n / 28;
    int c = n % 28;
    return (4 + (r * 20) / 28) * 28 + 4 + (c * 20) / 28;
  endfunction

  task automatic check(string name, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Advance one cycle and compare outputs on the falling edge.
  task automatic step();
    @(negedge clk);
    if (pixel_valid) begin
      if (pix_cnt >= 784) check("extra_pixel", pix_cnt, 783);
      else begin
        check("addr_seq", h2, exp_addr(pix_cnt));
        check("pixel_val", int'(pixel_o), exp_addr(pix_cnt) % 256);
        got[pix_cnt] = int'(pixel_o);
      end
      pix_cnt++;
    end
    if (image_done) begin
      done_cnt++;
      check("done_timing", pix_cnt, 783);
    end
    h2 = h1;
    h1 = int'(bram_address);
  endtask

  task automatic new_image();
    pix_cnt  = 0;
    done_cnt = 0;
  endtask

  task automatic run_to_idle(int budget, string tag);
    int n = 0;
    while (pix_cnt < 784 && n < budget) begin
      step();
      n++;
    end
    if (pix_cnt < 784) check({tag, "_timeout"}, pix_cnt, 784);
    repeat (4) step();
    check({tag, "_count"}, pix_cnt, 784);
    check({tag, "_done_once"}, done_cnt, 1);
    check({tag, "_idle_valid"}, int'(pixel_valid), 0);
    check({tag, "_idle_addr"}, int'(bram_address), 0);
    $display("[TB] %s: %0d pixels, %0d image_done pulses", tag, pix_cnt, done_cnt);
  endtask

  initial begin
    int n;
    repeat (3) step();
    check("rst_valid", int'(pixel_valid), 0);
    check("rst_done", int'(image_done), 0);
    check("rst_addr", int'(bram_address), 0);
    check("rst_pixel", int'(pixel_o), 0);
    reset = 1'b1;
    repeat (5) step();
    check("post_rst_valid", int'(pixel_valid), 0);
    check("post_rst_addr", int'(bram_address), 0);

    // Image 1: start held two cycles, plus a stray start during READ.
    new_image();
    start = 1'b1;
    step();
    check("first_addr", int'(bram_address), 116);
    check("no_early_valid", int'(pixel_valid), 0);
    step();
    start = 1'b0;
    step();
    check("first_valid", int'(pixel_valid), 1);
    check("first_pixel", int'(pixel_o), 116);
    repeat (200) step();
    start = 1'b1;
    step();
    start = 1'b0;
    run_to_idle(1000, "img1");
    check("lit_px1", got[1], 116);
    check("lit_px2", got[2], 117);
    check("lit_px3", got[3], 118);
    check("lit_px5", got[5], 119);
    check("lit_px28", got[28], 116);
    check("lit_px56", got[56], 144);
    check("lit_last", got[783], 667 % 256);
    repeat (20) step();
    check("no_relaunch", pix_cnt, 784);

    // Image 2: single-cycle start after IDLE.
    new_image();
    start = 1'b1;
    step();
    start = 1'b0;
    run_to_idle(1000, "img2");

    // Image 3: reset at pixel 300.
    new_image();
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (pix_cnt < 300 && n < 1000) begin
      step();
      n++;
    end
    check("reach_300", pix_cnt, 300);
    reset = 1'b0;
    #1;
    check("midrst_valid", int'(pixel_valid), 0);
    check("midrst_done", int'(image_done), 0);
    check("midrst_addr", int'(bram_address), 0);
    check("midrst_pixel", int'(pixel_o), 0);
    repeat (2) step();
    check("midrst_no_done", done_cnt, 0);
    reset = 1'b1;
    repeat (5) step();
    check("midrst_idle", int'(pixel_valid), 0);
    $display("[TB] img3: reset after %0d pixels", pix_cnt);

    // Image 4, then a start placed in the very first IDLE cycle after it.
    new_image();
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (pix_cnt < 784 && n < 1000) begin
      step();
      n++;
    end
    check("img4_count", pix_cnt, 784);
    check("img4_done_once", done_cnt, 1);
    $display("[TB] img4: %0d pixels, %0d image_done pulses", pix_cnt, done_cnt);
    step();
    new_image();
    start = 1'b1;
    step();
    start = 1'b0;
    check("b2b_accept", int'(bram_address), 116);
    run_to_idle(1000, "img5");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
